// File: rtl/alu_seq.sv
// Registered, valid/ready-handshaked ALU with carry/overflow/zero flags and signed SLT.
// Define ALU_MUL_EN to add the multi-cycle shift-add multiply on opcode 3'b011.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd1
`ifdef ALU_MUL_EN
        , S_MUL = 2'd2
`endif
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   is_mul;

    assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(W);

    logic [W-1:0]   a_q, a_d;
    logic [2*W-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] p_step;
    logic           mul_last;

    assign is_mul   = (f == 3'b011);
    assign mul_last = (cnt_q == CW'(W - 1));
    // Upper half accumulates the multiplicand; the product shifts right past the multiplier.
    assign mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    assign p_step   = {mul_sum, p_q[W-1:1]};
`else
    assign is_mul = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_d = is_mul ? S_MUL : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: if (mul_last) state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = rst_n;
            S_DONE: begin
                in_ready  = rst_n && out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    logic [W:0]   sum, diff;
    logic [W-1:0] alu_y;
    logic         alu_c, alu_v, ovf_add, ovf_sub;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign ovf_add = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    assign ovf_sub = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (f)
            3'b000: alu_y = a & b;
            3'b001: alu_y = a | b;
            3'b010: begin
                alu_y = sum[W-1:0];
                alu_c = sum[W];
                alu_v = ovf_add;
            end
            3'b100: alu_y = a ^ b;
            3'b101: alu_y = ~(a | b);
            3'b110: begin
                alu_y = diff[W-1:0];
                alu_c = ~diff[W];
                alu_v = ovf_sub;
            end
            3'b111: alu_y = {{(W-1){1'b0}}, diff[W-1] ^ ovf_sub};
            default: alu_y = '0;
        endcase
    end

    logic [W-1:0] y_q, y_d, y_hi_q, y_hi_d;
    logic         zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

    always_comb begin
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (accept && !is_mul) begin
            y_d     = alu_y;
            y_hi_d  = '0;
            zero_d  = (alu_y == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
        end
`ifdef ALU_MUL_EN
        else if (state_q == S_MUL && mul_last) begin
            y_d     = p_step[W-1:0];
            y_hi_d  = p_step[2*W-1:W];
            zero_d  = (p_step == '0);
            carry_d = |p_step[2*W-1:W];
            ovf_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_hi_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ALU_MUL_EN
    always_comb begin
        a_d   = a_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        if (accept && is_mul) begin
            a_d   = a;
            p_d   = {{W{1'b0}}, b};
            cnt_d = '0;
        end else if (state_q == S_MUL) begin
            p_d   = p_step;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   f = '0;
  logic         in_ready, out_valid, zero, carry_out, overflow;
  logic [W-1:0] y, y_hi;

  int n_chk = 0, n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .zero(zero), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic [2:0] mf,
                       output logic [15:0] ey, output logic [15:0] ehi,
                       output logic ez, output logic ec, output logic ev);
    int unsigned ua, ub, p;
    int sa, sb, r;
    ua = ma; ub = mb; sa = $signed(ma); sb = $signed(mb);
    ey = 0; ehi = 0; ec = 0; ev = 0;
    case (mf)
      3'd0: ey = ma & mb;
      3'd1: ey = ma | mb;
      3'd2: begin
        p = ua + ub; ey = p[15:0]; ec = (p > 65535);
        r = sa + sb; ev = (r > 32767) || (r < -32768);
      end
      3'd3: begin
`ifdef ALU_MUL_EN
        p = ua * ub; ey = p[15:0]; ehi = p[31:16]; ec = (ehi != 0);
`endif
      end
      3'd4: ey = ma ^ mb;
      3'd5: ey = ~(ma | mb);
      3'd6: begin
        p = ua - ub; ey = p[15:0]; ec = (ua >= ub);
        r = sa - sb; ev = (r > 32767) || (r < -32768);
      end
      default: ey = (sa < sb) ? 16'd1 : 16'd0;
    endcase
    ez = (ey == 0) && (ehi == 0);
  endtask

  task automatic chk_result(input string tag, input logic [15:0] ma, input logic [15:0] mb,
                            input logic [2:0] mf);
    logic [15:0] ey, ehi;
    logic ez, ec, ev;
    model(ma, mb, mf, ey, ehi, ez, ec, ev);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".y_hi"}, y_hi, ehi);
    chk({tag, ".flags"}, {zero, carry_out, overflow}, {ez, ec, ev});
  endtask

  // Issue one op with out_ready=1, scramble inputs while busy, check latency and result.
  task automatic run_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input logic [2:0] of);
    int cyc, lat;
    lat = 1;
`ifdef ALU_MUL_EN
    if (of == 3'b011) lat = W + 1;
`endif
    @(negedge clk);
    out_ready = 1'b1;
    chk({tag, ".in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; a = oa; b = ob; f = of;
    @(negedge clk);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk({tag, ".busy_in_ready"}, in_ready, 1'b0);
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); f = 3'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, ".latency"}, cyc, lat);
    chk_result(tag, oa, ob, of);
  endtask

  initial begin
    logic [15:0] ra, rb, hold_y;
    logic [2:0]  rf;
    logic [15:0] sa_t[4], sb_t[4];
    logic [2:0]  sf_t[4];

    #2;
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.outs", {out_valid, y, y_hi, zero, carry_out, overflow}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("add_carry", 16'hFFFF, 16'h0001, 3'b010);
    chk("add_carry.const", {y, zero, carry_out, overflow}, {16'h0000, 3'b110});
    run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b010);
    chk("add_ovf.const", {y, carry_out, overflow}, {16'h8000, 2'b01});
    run_op("sub_borrow", 16'h0003, 16'h0005, 3'b110);
    chk("sub_borrow.const", {y, carry_out}, {16'hFFFE, 1'b0});
    run_op("slt_neg", 16'h8000, 16'h0001, 3'b111);
    chk("slt_neg.const", y, 16'h0001);
    run_op("slt_ovf", 16'h7FFF, 16'h8000, 3'b111);
    chk("slt_ovf.const", y, 16'h0000);
    run_op("mul", 16'h1234, 16'h0100, 3'b011);
`ifdef ALU_MUL_EN
    chk("mul.const", {y_hi, y, carry_out}, {16'h0012, 16'h3400, 1'b1});
`else
    chk("mul.const", {y_hi, y, zero}, {32'h0, 1'b1});
`endif

    // Backpressure: result must hold and nothing new may be accepted.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 16'hF0F3; b = 16'h3C3F; f = 3'b000;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; f = 3'b010;
    chk_result("bp", 16'hF0F3, 16'h3C3F, 3'b000);
    hold_y = y;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.in_ready", in_ready, 1'b0);
      chk("bp.hold", {out_valid, y}, {1'b1, hold_y});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp.drain", out_valid, 1'b0);

    // Back-to-back stream of single-cycle ops.
    for (int i = 0; i < 4; i++) begin
      sa_t[i] = 16'($urandom); sb_t[i] = 16'($urandom);
      do sf_t[i] = 3'($urandom); while (sf_t[i] == 3'b011);
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) chk_result("stream", sa_t[i-1], sb_t[i-1], sf_t[i-1]);
      chk("stream.in_ready", in_ready, 1'b1);
      if (i < 4) begin
        in_valid = 1'b1; a = sa_t[i]; b = sb_t[i]; f = sf_t[i];
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("stream.end", out_valid, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'hABCD; b = 16'h00FF;
`ifdef ALU_MUL_EN
    f = 3'b011;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
`else
    f = 3'b001; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst.outs", {out_valid, y, y_hi, zero, carry_out, overflow}, '0);
    chk("midrst.in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("postrst.state", {in_ready, out_valid}, 2'b10);
    run_op("postrst_add", 16'h1234, 16'h4321, 3'b010);

    // Randomized traffic, biased toward the arithmetic corners.
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rf = 3'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {ra[15], {15{~ra[15]}}};
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 2));
      run_op("rand", ra, rb, rf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
